// File: rtl/dac_updater_if.sv
// Command/data stream link between dac_updater (master) and the i2c_master (slave).
interface dac_updater_if;
    logic [6:0] i2c_cmd_address;
    logic       i2c_cmd_start;
    logic       i2c_cmd_read;
    logic       i2c_cmd_write;
    logic       i2c_cmd_write_multiple;
    logic       i2c_cmd_stop;
    logic       i2c_cmd_valid;
    logic       i2c_cmd_ready;
    logic [7:0] i2c_data;
    logic       i2c_data_valid;
    logic       i2c_data_ready;
    logic       i2c_data_last;
    logic       i2c_busy;
    logic       i2c_missed_ack;

    modport master (
        output i2c_cmd_address, i2c_cmd_start, i2c_cmd_read, i2c_cmd_write,
               i2c_cmd_write_multiple, i2c_cmd_stop, i2c_cmd_valid,
               i2c_data, i2c_data_valid, i2c_data_last,
        input  i2c_cmd_ready, i2c_data_ready, i2c_busy, i2c_missed_ack
    );

    modport slave (
        input  i2c_cmd_address, i2c_cmd_start, i2c_cmd_read, i2c_cmd_write,
               i2c_cmd_write_multiple, i2c_cmd_stop, i2c_cmd_valid,
               i2c_data, i2c_data_valid, i2c_data_last,
        output i2c_cmd_ready, i2c_data_ready, i2c_busy, i2c_missed_ack
    );
endinterface

// File: rtl/dac_updater.sv
// Multi-channel DAC refresh sequencer: shadows per channel, round-robin 3-byte I2C writes.
// Define DAC_UPDATER_RETRY_EN to re-queue NACKed channels instead of dropping them.
module dac_updater #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned VALUE_W  = 12,
    parameter logic [6:0]  I2C_ADDR = 7'h60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                upd_valid,
    input  logic [4:0]          upd_ch,
    input  logic [VALUE_W-1:0]  upd_value,
    output logic                upd_ready,
    dac_updater_if.master       i2c,
    output logic                busy,
    output logic [CHANNELS-1:0] dirty,
    output logic [7:0]          nack_count
);

`ifdef DAC_UPDATER_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    localparam logic [5:0] NumCh  = 6'(CHANNELS);
    localparam logic [4:0] LastCh = 5'(CHANNELS - 1);

    typedef enum logic [2:0] {StIdle, StCmd, StB0, StB1, StB2, StDone} state_e;

    state_e              state_q, state_d;
    logic [CHANNELS-1:0] dirty_q, dirty_d;
    logic [VALUE_W-1:0]  shadow_q [CHANNELS];
    logic [VALUE_W-1:0]  shadow_d [CHANNELS];
    logic [4:0]          last_q, last_d;
    logic [4:0]          tx_ch_q, tx_ch_d;
    logic [VALUE_W-1:0]  tx_val_q, tx_val_d;
    logic                nack_seen_q, nack_seen_d;
    logic [7:0]          nack_count_q, nack_count_d;
    logic                ready_q;

    logic                upd_hit, grant, grant_found, done_exit, nack_any, retry;
    logic [4:0]          grant_ch;
    logic [5:0]          cand;
    logic [VALUE_W-1:0]  grant_val;
    logic [15:0]         tx_word;

    assign upd_hit   = upd_valid && ({1'b0, upd_ch} < NumCh);
    assign grant     = (state_q == StIdle) && grant_found;
    assign done_exit = (state_q == StDone) && !i2c.i2c_busy;
    assign nack_any  = nack_seen_q | i2c.i2c_missed_ack;
    assign retry     = RetryEn && done_exit && nack_any;
    assign tx_word   = 16'(tx_val_q);

    // First dirty channel searching upward from last+1; one subtraction covers the wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        grant_val   = '0;
        cand        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = {1'b0, last_q} + 6'd1 + 6'(i);
            if (cand >= NumCh) cand = cand - NumCh;
            for (int c = 0; c < CHANNELS; c++) begin
                if (!grant_found && cand[4:0] == 5'(c) && dirty_q[c]) begin
                    grant_found = 1'b1;
                    grant_ch    = cand[4:0];
                end
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_ch == 5'(c)) grant_val = shadow_q[c];
        end
    end

    // Set from a same-cycle update is applied last so it wins over the grant clear.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            shadow_d[c] = shadow_q[c];
            dirty_d[c]  = dirty_q[c];
            if (grant && grant_ch == 5'(c)) dirty_d[c] = 1'b0;
            if (retry && tx_ch_q == 5'(c))  dirty_d[c] = 1'b1;
            if (upd_hit && upd_ch == 5'(c)) begin
                dirty_d[c]  = 1'b1;
                shadow_d[c] = upd_value;
            end
        end
    end

    always_comb begin
        last_d       = last_q;
        tx_ch_d      = tx_ch_q;
        tx_val_d     = tx_val_q;
        nack_seen_d  = nack_seen_q;
        nack_count_d = nack_count_q;
        if (grant) begin
            last_d   = grant_ch;
            tx_ch_d  = grant_ch;
            tx_val_d = grant_val;
        end
        if (state_q != StIdle && i2c.i2c_missed_ack) nack_seen_d = 1'b1;
        if (done_exit) begin
            nack_seen_d = 1'b0;
            if (nack_any && nack_count_q != 8'hFF) nack_count_d = nack_count_q + 8'd1;
        end
    end

    always_comb begin
        state_d            = state_q;
        i2c.i2c_cmd_valid  = 1'b0;
        i2c.i2c_data_valid = 1'b0;
        i2c.i2c_data_last  = 1'b0;
        i2c.i2c_data       = 8'h00;
        unique case (state_q)
            StIdle: if (grant) state_d = StCmd;
            StCmd: begin
                i2c.i2c_cmd_valid = 1'b1;
                if (i2c.i2c_cmd_ready) state_d = StB0;
            end
            StB0: begin
                i2c.i2c_data_valid = 1'b1;
                i2c.i2c_data       = {tx_ch_q, 2'b00, 1'b0};
                if (i2c.i2c_data_ready) state_d = StB1;
            end
            StB1: begin
                i2c.i2c_data_valid = 1'b1;
                i2c.i2c_data       = tx_word[15:8];
                if (i2c.i2c_data_ready) state_d = StB2;
            end
            StB2: begin
                i2c.i2c_data_valid = 1'b1;
                i2c.i2c_data_last  = 1'b1;
                i2c.i2c_data       = tx_word[7:0];
                if (i2c.i2c_data_ready) state_d = StDone;
            end
            StDone: if (done_exit) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dirty_q      <= '0;
            last_q       <= LastCh;
            tx_ch_q      <= '0;
            tx_val_q     <= '0;
            nack_seen_q  <= 1'b0;
            nack_count_q <= '0;
            ready_q      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) shadow_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            dirty_q      <= dirty_d;
            last_q       <= last_d;
            tx_ch_q      <= tx_ch_d;
            tx_val_q     <= tx_val_d;
            nack_seen_q  <= nack_seen_d;
            nack_count_q <= nack_count_d;
            ready_q      <= 1'b1;
            for (int c = 0; c < CHANNELS; c++) shadow_q[c] <= shadow_d[c];
        end
    end

    assign i2c.i2c_cmd_address        = I2C_ADDR;
    assign i2c.i2c_cmd_start          = 1'b0;
    assign i2c.i2c_cmd_read           = 1'b0;
    assign i2c.i2c_cmd_write          = 1'b0;
    assign i2c.i2c_cmd_write_multiple = 1'b1;
    assign i2c.i2c_cmd_stop           = 1'b1;

    assign upd_ready  = ready_q;
    assign busy       = (state_q != StIdle);
    assign dirty      = dirty_q;
    assign nack_count = nack_count_q;

endmodule

// File: tb/tb_dac_updater.sv
// Bench for dac_updater: I2C slave model, directed scenarios and a randomized last-value scoreboard.
module tb_dac_updater;
    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic [4:0]  upd_ch;
    logic [11:0] upd_value;
    logic        upd_ready;
    logic        busy;
    logic [1:0]  dirty;
    logic [7:0]  nack_count;

    dac_updater_if bus ();

    dac_updater #(
        .CHANNELS (2),
        .VALUE_W  (12),
        .I2C_ADDR (7'h60)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_ch     (upd_ch),
        .upd_value  (upd_value),
        .upd_ready  (upd_ready),
        .i2c        (bus),
        .busy       (busy),
        .dirty      (dirty),
        .nack_count (nack_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, expv);
        end
    endtask

    // Expected on-wire frame: register byte (ch<<3), then the code as a 16-bit big-endian word.
    function automatic logic [23:0] frame(input int ch, input int val);
        logic [4:0]  c5;
        logic [15:0] v16;
        c5  = ch[4:0];
        v16 = 16'(val);
        return {c5, 3'b000, v16};
    endfunction

    // Slave model state
    bit          rnd_mode = 1'b0;
    bit          hold_busy = 1'b0;
    int          nack_budget = 0;
    bit          nack_pending = 1'b0;
    bit          in_txn = 1'b0;
    int          byte_idx = 0;
    int          busy_cnt = 0;
    logic [7:0]  bytes [3];
    logic [23:0] txq [$];
    logic [23:0] expq [$];

    initial begin
        bus.i2c_cmd_ready  = 1'b0;
        bus.i2c_data_ready = 1'b0;
        bus.i2c_busy       = 1'b0;
        bus.i2c_missed_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.i2c_cmd_ready  = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.i2c_data_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.i2c_missed_ack = nack_pending;
            nack_pending = 1'b0;
            #1;
            if (rst) begin
                in_txn   = 1'b0;
                byte_idx = 0;
                busy_cnt = 0;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (bus.i2c_cmd_valid && bus.i2c_cmd_ready) begin
                    in_txn   = 1'b1;
                    byte_idx = 0;
                    if (nack_budget > 0) begin
                        nack_budget--;
                        nack_pending = 1'b1;
                    end
                end
                if (bus.i2c_data_valid && bus.i2c_data_ready && byte_idx < 3) begin
                    check_eq($sformatf("data_last_b%0d", byte_idx), 32'(bus.i2c_data_last),
                             32'(byte_idx == 2));
                    bytes[byte_idx] = bus.i2c_data;
                    byte_idx++;
                    if (byte_idx == 3) begin
                        txq.push_back({bytes[0], bytes[1], bytes[2]});
                        in_txn   = 1'b0;
                        busy_cnt = 2;
                    end
                end
            end
            bus.i2c_busy = hold_busy || in_txn || (busy_cnt > 0);
        end
    end

    task automatic upd(input int ch, input int val);
        upd_valid = 1'b1;
        upd_ch    = ch[4:0];
        upd_value = val[11:0];
        @(negedge clk);
        #2;
        upd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int q = 0;
        for (int n = 0; n < budget && q < 3; n++) begin
            @(negedge clk);
            #3;
            if (!busy && dirty == 2'b00 && !bus.i2c_busy) q++;
            else q = 0;
        end
        check_eq({tag, "_quiet"}, 32'(q >= 3), 32'd1);
    endtask

    task automatic check_txns(input string tag, input int start);
        check_eq({tag, "_count"}, 32'(txq.size() - start), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (start + i < txq.size())
                check_eq($sformatf("%s_tx%0d", tag, i), 32'(txq[start + i]), 32'(expq[i]));
        end
    endtask

    task automatic wait_b1(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            #2;
            if (in_txn && byte_idx == 1) seen = 1'b1;
        end
        check_eq({tag, "_b1_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        #2;
    endtask

    int          start;
    int          lastv [2];
    bit          wr [2];
    int          bad;
    logic [23:0] found;
    bit          hit;

    initial begin
        rst       = 1'b1;
        upd_valid = 1'b0;
        upd_ch    = '0;
        upd_value = '0;
        repeat (2) @(negedge clk);
        #2;
        check_eq("rst_upd_ready", 32'(upd_ready), 0);
        check_eq("rst_outputs", {busy, dirty, bus.i2c_cmd_valid, bus.i2c_data_valid,
                                 bus.i2c_data_last, bus.i2c_data}, 0);
        check_eq("rst_nack_count", 32'(nack_count), 0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check_eq("upd_ready_high", 32'(upd_ready), 1);
        check_eq("cmd_consts", {bus.i2c_cmd_address, bus.i2c_cmd_start, bus.i2c_cmd_read,
                                bus.i2c_cmd_write, bus.i2c_cmd_write_multiple,
                                bus.i2c_cmd_stop}, {7'h60, 5'b00011});

        // Single update with latency checks
        start = txq.size();
        upd(0, 'hABC);
        check_eq("single_dirty_set", 32'(dirty), 32'b01);
        check_eq("single_busy_arb", 32'(busy), 0);
        @(negedge clk);
        #2;
        check_eq("single_cmd_valid", 32'(bus.i2c_cmd_valid), 1);
        check_eq("single_dirty_clr", 32'(dirty), 0);
        wait_quiet("single", 200);
        expq = '{frame(0, 'hABC)};
        check_txns("single", start);

        // Round-robin: both dirty while a ch0 write is stuck in its tail, last == 0
        start = txq.size();
        hold_busy = 1'b1;
        upd(0, 'h777);
        repeat (8) @(negedge clk);
        #2;
        upd(0, 'h456);
        upd(1, 'h123);
        check_eq("rr_dirty_both", 32'(dirty), 32'b11);
        check_eq("rr_busy_held", 32'(busy), 1);
        hold_busy = 1'b0;
        wait_quiet("rr", 200);
        expq = '{frame(0, 'h777), frame(1, 'h123), frame(0, 'h456)};
        check_txns("rr", start);

        // Coalescing
        start = txq.size();
        hold_busy = 1'b1;
        upd(1, 'h555);
        repeat (8) @(negedge clk);
        #2;
        upd(0, 'h001);
        upd(0, 'h002);
        upd(0, 'h003);
        hold_busy = 1'b0;
        wait_quiet("coal", 200);
        expq = '{frame(1, 'h555), frame(0, 'h003)};
        check_txns("coal", start);

        // Update during B1 re-dirties the channel
        start = txq.size();
        upd(0, 'h200);
        wait_b1("inflight");
        upd(0, 'h201);
        wait_quiet("inflight", 200);
        expq = '{frame(0, 'h200), frame(0, 'h201)};
        check_txns("inflight", start);

        // Out-of-range channel ignored
        start = txq.size();
        upd(5, 'h3AA);
        check_eq("ignored_dirty", 32'(dirty), 0);
        wait_quiet("ignored", 50);
        check_eq("ignored_txns", 32'(txq.size() - start), 0);

        // Single NACK
        start = txq.size();
        nack_budget = 1;
        upd(1, 'h111);
        wait_quiet("nack1", 300);
        check_eq("nack1_count", 32'(nack_count), 1);
`ifdef DAC_UPDATER_RETRY_EN
        expq = '{frame(1, 'h111), frame(1, 'h111)};
`else
        expq = '{frame(1, 'h111)};
`endif
        check_txns("nack1", start);

        // Randomized traffic with a random-ready slave; last write per channel must land
        start = txq.size();
        wr = '{0, 0};
        rnd_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int ch, v;
                ch = int'($urandom_range(0, 3));
                v  = int'($urandom_range(0, 4095));
                if (ch < 2) begin
                    lastv[ch] = v;
                    wr[ch]    = 1'b1;
                end
                upd(ch, v);
            end else begin
                @(negedge clk);
                #2;
            end
        end
        wait_quiet("rand", 3000);
        rnd_mode = 1'b0;
        bad = 0;
        for (int i = start; i < txq.size(); i++)
            if (txq[i][23:19] >= 5'd2 || txq[i][18:16] != 3'b000) bad++;
        check_eq("rand_bad_frames", 32'(bad), 0);
        for (int c = 0; c < 2; c++) begin
            hit   = 1'b0;
            found = '0;
            for (int i = start; i < txq.size(); i++)
                if (txq[i][23:19] == 5'(c)) begin
                    hit   = 1'b1;
                    found = txq[i];
                end
            if (wr[c]) begin
                check_eq($sformatf("rand_ch%0d_sent", c), 32'(hit), 1);
                check_eq($sformatf("rand_ch%0d_last", c), 32'(found), 32'(frame(c, lastv[c])));
            end
        end

        // NACK counter saturation
        nack_budget = 300;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            #2;
            if (nack_budget == 0 && !busy) break;
            if (!busy && dirty == 2'b00 && !bus.i2c_busy) upd(0, n & 'hFFF);
        end
        check_eq("sat_budget_used", 32'(nack_budget), 0);
        wait_quiet("sat", 500);
        check_eq("sat_nack_count", 32'(nack_count), 255);

        // Reset during B1
        upd(0, 'h0F0);
        upd(1, 'h0E1);
        wait_b1("rstmid");
        check_eq("rstmid_pre_dirty", 32'(dirty), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_eq("rstmid_busy", 32'(busy), 0);
        check_eq("rstmid_dirty", 32'(dirty), 0);
        check_eq("rstmid_valids", {bus.i2c_cmd_valid, bus.i2c_data_valid}, 0);
        check_eq("rstmid_nack_count", 32'(nack_count), 0);
        check_eq("rstmid_upd_ready", 32'(upd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        start = txq.size();
        upd(1, 'h3C5);
        wait_quiet("post_rst", 200);
        expq = '{frame(1, 'h3C5)};
        check_txns("post_rst", start);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dac_updater.md
# dac_updater

Multi-channel DAC refresh sequencer that sits between application logic and the `i2c_master` command/data stream interface. It holds a shadow value per DAC channel and marks channels dirty on update. It writes each dirty channel to an MCP47FEB-class device using a 3-byte write_multiple+stop transaction, serving channels round-robin. It counts NACKed transactions.

## Interface
Parameters:
- `CHANNELS`, 2 — number of DAC channels (1..32); channel c maps to device register c.
- `VALUE_W`, 12 — DAC code width (1..16).
- `I2C_ADDR`, 7'h60 — 7-bit device address.

Ports:
- `clk` in 1 — system clock (clk100 domain).
- `rst` in 1 — synchronous, active-high reset.
- `upd_valid` in 1 — update request.
- `upd_ch` in 5 — target channel; values ≥ CHANNELS are ignored.
- `upd_value` in VALUE_W — new DAC code.
- `upd_ready` out 1 — update accepted; tied high after reset.
- `i2c_cmd_address` out 7 — driven from `I2C_ADDR`.
- `i2c_cmd_start` out 1 — constant 0.
- `i2c_cmd_read` out 1 — constant 0.
- `i2c_cmd_write` out 1 — constant 0.
- `i2c_cmd_write_multiple` out 1 — constant 1.
- `i2c_cmd_stop` out 1 — constant 1.
- `i2c_cmd_valid` out 1 — command strobe.
- `i2c_cmd_ready` in 1 — command accepted by master.
- `i2c_data` out 8 — write byte.
- `i2c_data_valid` out 1 — byte strobe.
- `i2c_data_ready` in 1 — byte accepted.
- `i2c_data_last` out 1 — high on byte 2 only.
- `i2c_busy` in 1 — master busy.
- `i2c_missed_ack` in 1 — single-cycle NACK pulse from the master.
- `busy` out 1 — transaction in flight (state ≠ IDLE).
- `dirty` out CHANNELS — per-channel pending flags.
- `nack_count` out 8 — saturating NACK counter.

## Operation
- **Shadow update:** when `upd_valid` is high and `upd_ch < CHANNELS`, `shadow[upd_ch] <= upd_value` and `dirty[upd_ch] <= 1`. This happens in every state.
- **Arbitration in IDLE:** if any dirty bit is set, pick the first dirty channel searching upward from `last+1`, wrapping modulo CHANNELS. Then:
  - latch `tx_ch` and `tx_val <= shadow[ch]`;
  - clear `dirty[ch]`;
  - set `last <= ch`;
  - go to CMD.
- **Clear vs. set collision:** if an update to the same channel arrives in the same cycle as the clear, the set wins. That channel stays dirty and carries the new value.
- **State machine:**
  - IDLE → CMD (dirty present).
  - CMD: assert `i2c_cmd_valid`; on `i2c_cmd_ready & i2c_cmd_valid` → B0.
  - B0: `i2c_data = {tx_ch[4:0], 2'b00, 1'b0}`.
  - B1: `i2c_data = tx_val` zero-extended to 16 bits, bits [15:8].
  - B2: `i2c_data = ` bits [7:0], with `i2c_data_last = 1`.
  - Each of B0/B1/B2 holds `i2c_data_valid` high until `i2c_data_ready`, then advances.
  - B2 → DONE.
  - DONE: wait for `i2c_busy == 0` with no `i2c_cmd_valid` pending → IDLE.
- **NACK handling:** any `i2c_missed_ack` pulse from CMD through DONE sets a `nack_seen` flag. On DONE → IDLE with `nack_seen`:
  - `nack_count` increments, saturating at 255;
  - retry behaviour is set by the Configuration section;
  - `nack_seen` clears.
- Updates to `tx_ch` while its transaction is in flight do not alter `tx_val`. They re-set `dirty`, so the new value is sent in a later transaction.

## Timing
- **Reset values:**
  - `upd_ready` = 0 during reset, 1 after;
  - `i2c_cmd_valid` = 0, `i2c_data_valid` = 0, `i2c_data_last` = 0, `i2c_data` = 0;
  - `busy` = 0, `dirty` = 0, `nack_count` = 0;
  - all shadows = 0, `last` = CHANNELS-1 (so the first grant goes to ch 0).
- Update at cycle N: `dirty` visible at N+1.
- From IDLE with dirty at N: `i2c_cmd_valid` high at N+1.
- Ready/valid handshakes:
  - Valid stays asserted until its handshake completes.
  - Valid drops in the cycle after acceptance unless the next byte's valid follows immediately.
  - Data is stable while valid is high.
- Minimum transaction: 1 (arb) + 1 (cmd) + 3 (bytes) + 1 (DONE) = 6 cycles, plus I2C bus time.
- Reset asserted mid-transaction: the FSM returns to IDLE and all valids drop the next cycle. The `i2c_master` is reset by the same `rst`.

## Configuration
- `DAC_UPDATER_RETRY_EN` defined: a NACKed channel has `dirty[tx_ch]` re-set at DONE → IDLE, so it is retried in round-robin order.
- Not defined: a NACKed transaction is dropped. Only `nack_count` records it.

## Test plan
- **Single update:** ch0 ← 0x0ABC with an ideal master model → one transaction with bytes 0x00, 0x0A, 0xBC; `data_last` on 0xBC only; `dirty` returns to 0.
- **Round-robin:** update ch1 = 0x123 and ch0 = 0x456 in the same idle window, with `last` = 0 → ch1 is sent first (bytes 0x08, 0x01, 0x23), then ch0.
- **Coalescing / in-flight update:**
  - 3 writes to ch0 (0x001, 0x002, 0x003) while idle-blocked → a single transaction carrying 0x003.
  - An update to ch0 during its B1 phase → a second transaction follows.
- **Ignored channel:** with CHANNELS=2, `upd_ch` = 5 → no dirty bit set and no transaction.
- **NACK:** pulse `missed_ack` during B0 → `nack_count` = 1. With `DAC_UPDATER_RETRY_EN` the channel is resent; without it, no retry. Force 300 NACKs → `nack_count` = 255.
- **Reset:** `rst` asserted during B1 → next cycle `busy` = 0, `dirty` = 0, valids = 0; a fresh update afterwards completes normally.
